pc_seq: RTL

- Parametrised program-counter sequencer for the 16-bit RISC core.
- Generates the fetch address each cycle. Supports sequential, PC-relative branch, absolute jump, call and return.
- Keeps an internal circular return-address stack (RAS) and honours a fetch stall.
- Sits between the decode/ALU next-PC select and instruction memory.

---
 rtl/pc_seq_if.sv | 41 ++++
 rtl/pc_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_seq_if.sv
// Next-PC select and status bundle between decode/ALU and the PC sequencer.
// With PC_TRAP_EN defined the bundle also carries trap and epc.
interface pc_seq_if #(
    parameter int PC_W      = 16,
    parameter int IMM_W     = 7,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic [2:0]       sel;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_out;
    logic             redirect;
    logic [CNT_W-1:0] ras_count;
    logic             ras_ovf;
    logic             ras_unf;
`ifdef PC_TRAP_EN
    logic             trap;
    logic [PC_W-1:0]  epc;
`endif

    modport master (
`ifdef PC_TRAP_EN
        output trap,
        input  epc,
`endif
        output stall, sel, imm, target,
        input  pc_out, redirect, ras_count, ras_ovf, ras_unf
    );

    modport slave (
`ifdef PC_TRAP_EN
        input  trap,
        output epc,
`endif
        input  stall, sel, imm, target,
        output pc_out, redirect, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer with a circular return-address stack and fetch stall.
// Optional trap entry (trap/epc, TRAP_VEC) is built only when PC_TRAP_EN is defined.
module pc_seq #(
    parameter int              PC_W      = 16,
    parameter int              IMM_W     = 7,
    parameter int              INC       = 1,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
`ifdef PC_TRAP_EN
    ,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(16'h0004)
`endif
) (
    input logic       clk,
    input logic       rst,
    pc_seq_if.slave   bus
);
    localparam int               PTR_W = $clog2(RAS_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0]  INC_V = PC_W'(INC);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'b000,
        SEL_BR   = 3'b001,
        SEL_JMP  = 3'b010,
        SEL_CALL = 3'b011,
        SEL_RET  = 3'b100
    } sel_e;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic             push;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  imm_ext;
    logic [PTR_W-1:0] top_idx;
`ifdef PC_TRAP_EN
    logic [PC_W-1:0]  epc_q, epc_d;
`endif

    always_comb begin
        seq_pc     = pc_q + INC_V;
        imm_ext    = {{(PC_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
        top_idx    = ptr_q - PTR_W'(1);
        pc_d       = pc_q;
        redirect_d = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;
`ifdef PC_TRAP_EN
        epc_d      = epc_q;
`endif
        if (!bus.stall) begin
            case (bus.sel)
                SEL_BR: begin
                    pc_d       = seq_pc + imm_ext;
                    redirect_d = 1'b1;
                end
                SEL_JMP: begin
                    pc_d       = bus.target;
                    redirect_d = 1'b1;
                end
                SEL_CALL: begin
                    // ptr always names the next free slot; when full it is also the oldest entry
                    push       = 1'b1;
                    ptr_d      = ptr_q + PTR_W'(1);
                    pc_d       = bus.target;
                    redirect_d = 1'b1;
                    if (cnt_q == FULL) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + CNT_W'(1);
                end
                SEL_RET: begin
                    if (cnt_q != '0) begin
                        pc_d       = ras_q[top_idx];
                        ptr_d      = top_idx;
                        cnt_d      = cnt_q - CNT_W'(1);
                        redirect_d = 1'b1;
                    end else begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end
                end
                default: pc_d = seq_pc;
            endcase
        end
`ifdef PC_TRAP_EN
        // A trap outranks stall and leaves the return stack and flags untouched
        if (bus.trap) begin
            pc_d       = TRAP_VEC;
            epc_d      = pc_q;
            redirect_d = 1'b1;
            ptr_d      = ptr_q;
            cnt_d      = cnt_q;
            ovf_d      = ovf_q;
            unf_d      = unf_q;
            push       = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef PC_TRAP_EN
            epc_q      <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
`ifdef PC_TRAP_EN
            epc_q      <= epc_d;
`endif
        end
    end

    // Stack contents are don't-care after reset, so the storage has no reset
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= seq_pc;
    end

    assign bus.pc_out    = pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.ras_count = cnt_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
`ifdef PC_TRAP_EN
    assign bus.epc       = epc_q;
`endif
endmodule
